// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage definitions: instruction/condition codes, the
// "no register" ID, the data word type and the E->M pipeline payload.
package y86_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CODE_W  = 4;

    typedef logic [WORD_W-1:0] word_t;

    // Instruction codes used by the execute stage
    localparam logic [CODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [CODE_W-1:0] I_CMOVXX = 4'h2;
    localparam logic [CODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [CODE_W-1:0] I_JXX    = 4'h7;

    // Condition function codes for jXX / cmovXX
    localparam logic [CODE_W-1:0] C_ALWAYS = 4'h0;
    localparam logic [CODE_W-1:0] C_LE     = 4'h1;
    localparam logic [CODE_W-1:0] C_L      = 4'h2;
    localparam logic [CODE_W-1:0] C_E      = 4'h3;
    localparam logic [CODE_W-1:0] C_NE     = 4'h4;
    localparam logic [CODE_W-1:0] C_GE     = 4'h5;
    localparam logic [CODE_W-1:0] C_G      = 4'h6;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    // E->M pipeline register payload
    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] icode;
        logic              cnd;
        word_t             val_e;
        word_t             val_a;
        logic [REG_W-1:0]  dst_e;
        logic [REG_W-1:0]  dst_m;
    } em_reg_t;

    // Payload of an empty (bubble) memory-stage slot
    function automatic em_reg_t em_bubble();
        em_reg_t b;
        b.valid = 1'b0;
        b.icode = I_NOP;
        b.cnd   = 1'b0;
        b.val_e = '0;
        b.val_a = '0;
        b.dst_e = RNONE;
        b.dst_m = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator.
//   zf, sf, of : condition-code flags
//   ifun       : condition function code
//   cnd        : condition result (0 for undefined function codes)
module cc_cond_eval
    import y86_pkg::*;
(
    input  logic              zf,
    input  logic              sf,
    input  logic              of,
    input  logic [CODE_W-1:0] ifun,
    output logic              cnd
);

    logic lt;

    // Signed less-than as seen through the flags
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_reg.sv
// Execute-stage back end: condition-code register, condition evaluation and
// the E->M pipeline register with stall/bubble control.
//   clk, rst_n                 : clock, async active-low reset
//   e_valid/e_icode/e_ifun     : execute-stage instruction
//   alu_out, alu_ovf           : ALU result and signed overflow
//   e_valA, e_dstE, e_dstM     : values forwarded to the memory stage
//   m_exc                      : downstream exception, blocks CC update
//   stall, bubble              : hazard control for the E->M register
//   cc_zf/cc_sf/cc_of          : registered condition codes
//   e_cnd                      : combinational condition for this instruction
//   M_*                        : registered memory-stage slot
module execute_cc_reg
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic [CODE_W-1:0] e_icode,
    input  logic [CODE_W-1:0] e_ifun,
    input  word_t             alu_out,
    input  logic              alu_ovf,
    input  word_t             e_valA,
    input  logic [REG_W-1:0]  e_dstE,
    input  logic [REG_W-1:0]  e_dstM,
    input  logic              m_exc,
    input  logic              stall,
    input  logic              bubble,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of,
    output logic              e_cnd,
    output logic              M_valid,
    output logic [CODE_W-1:0] M_icode,
    output logic              M_cnd,
    output word_t             M_valE,
    output word_t             M_valA,
    output logic [REG_W-1:0]  M_dstE,
    output logic [REG_W-1:0]  M_dstM
);

    logic    cc_we;
    logic    zf_d, sf_d, of_d;
    em_reg_t em_q, em_d;

    // Condition uses only the registered flags
    cc_cond_eval u_cond (
        .zf   (cc_zf),
        .sf   (cc_sf),
        .of   (cc_of),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

    assign cc_we = e_valid & (e_icode == I_OPQ) & ~m_exc & ~stall & ~bubble;

    // Next CC value
    always_comb begin
        zf_d = cc_zf;
        sf_d = cc_sf;
        of_d = cc_of;
        if (cc_we) begin
            zf_d = (alu_out == '0);
            sf_d = alu_out[WORD_W-1];
            of_d = alu_ovf;
        end
    end

    // Next E->M payload: stall > bubble > load; an invalid slot loads a bubble
    always_comb begin
        em_d = em_q;
        if (!stall) begin
            if (bubble || !e_valid) begin
                em_d = em_bubble();
            end else begin
                em_d.valid = 1'b1;
                em_d.icode = e_icode;
                em_d.cnd   = e_cnd;
                em_d.val_e = alu_out;
                em_d.val_a = e_valA;
                em_d.dst_e = ((e_icode == I_CMOVXX) && !e_cnd) ? RNONE : e_dstE;
                em_d.dst_m = e_dstM;
            end
        end
    end

    // CC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else begin
            cc_zf <= zf_d;
            cc_sf <= sf_d;
            cc_of <= of_d;
        end
    end

    // E->M register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= em_bubble();
        end else begin
            em_q <= em_d;
        end
    end

    assign M_valid = em_q.valid;
    assign M_icode = em_q.icode;
    assign M_cnd   = em_q.cnd;
    assign M_valE  = em_q.val_e;
    assign M_valA  = em_q.val_a;
    assign M_dstE  = em_q.dst_e;
    assign M_dstM  = em_q.dst_m;

endmodule

// File: doc/execute_cc_reg.md
# execute_cc_reg

Execute-stage back end of the Y86 datapath: consumes the 64-bit ALU result and overflow bit produced by the add/sub units, maintains the condition-code register (ZF/SF/OF), evaluates jXX/cmovXX conditions, and captures the execute results into the E→M pipeline register. It sits between the ALU and the memory stage, and provides stall/bubble control for the hazard unit.

## Interface
- No parameters; data width is fixed at 64 bits, register IDs at 4 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- e_valid  in  1  execute-stage slot holds a real instruction
- e_icode  in  4  instruction code (OPq=6, jXX=7, cmovXX=2, NOP=1)
- e_ifun  in  4  function/condition field
- alu_out  in  64  ALU result (valE)
- alu_ovf  in  1  ALU signed overflow
- e_valA  in  64  operand A forwarded to memory stage
- e_dstE  in  4  destination for valE (0xF = none)
- e_dstM  in  4  destination for memory load (0xF = none)
- m_exc  in  1  exception present in M or W stage; inhibits CC update
- stall  in  1  hold the E→M register
- bubble  in  1  load a NOP into the E→M register
- cc_zf, cc_sf, cc_of  out  1 each  current condition-code register
- e_cnd  out  1  combinational condition result for this instruction
- M_valid  out  1  memory-stage slot valid
- M_icode  out  4  registered icode
- M_cnd  out  1  registered condition
- M_valE  out  64  registered alu_out
- M_valA  out  64  registered e_valA
- M_dstE, M_dstM  out  4 each  registered destinations

## Operation
- Condition evaluation uses the registered CC, never the flags being written this cycle. ifun decoding: 0 = always; 1 = le (SF^OF)|ZF; 2 = l (SF^OF); 3 = e (ZF); 4 = ne (~ZF); 5 = ge ~(SF^OF); 6 = g ~(SF^OF)&~ZF; 7–15 = 0.
- e_cnd is driven for every icode. It is meaningful only for jXX and cmovXX.
- Effective dstE: if e_icode==cmovXX and e_cnd==0, 0xF; otherwise e_dstE.
- Next flags: ZF = (alu_out == 0); SF = alu_out[63]; OF = alu_ovf.
- CC write enable = e_valid & (e_icode==OPq) & ~m_exc & ~stall & ~bubble.
- E→M register priority: stall > bubble > load.
  - stall: all M_* hold.
  - bubble: M_valid=0, M_icode=NOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=0xF.
  - load: capture the current execute values, including the effective dstE and e_cnd. If e_valid=0, load the bubble values.
- stall and bubble asserted together: stall wins, and the CC does not update.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - CC: ZF=1, SF=0, OF=0.
  - M_* take the bubble values: M_valid=0, M_icode=NOP, dst=0xF, data=0.
- Reset mid-operation discards the in-flight E→M contents immediately. No partial CC update occurs.
- e_cnd is combinational from e_ifun and the CC, with zero latency.
- CC update: flags are visible on cc_* one cycle after the OPq edge. An instruction executing in the following cycle observes the new flags.
- M_* latency: 1 cycle from execute inputs.
- Back-to-back OPq instructions update the CC on every edge. A jXX immediately after an OPq sees that OPq's flags.

## Structure
- Package y86_pkg holds:
  - icode constants (NOP, OPq, JXX, CMOVXX);
  - condition ifun constants (C_ALWAYS..C_G);
  - RNONE = 4'hF;
  - a typedef for the 64-bit word.
- One sub-module, cc_cond_eval: a purely combinational (zf, sf, of, ifun) → cnd block. It is reusable by the sequential processor.
- The top level contains the CC flops, the E→M flops and the enable/priority logic.

## Test plan
- Reset, then release: cc_zf=1, cc_sf=0, cc_of=0; M_valid=0, M_icode=1, M_dstE=0xF.
- OPq with alu_out=0xFFFF_FFFF_FFFF_FFFE, alu_ovf=0 → next cycle SF=1, ZF=0, OF=0. A following jXX ifun=2 (l) gives e_cnd=1; ifun=3 (e) gives e_cnd=0.
- OPq with alu_out=0x8000_0000_0000_0000 and alu_ovf=1 → SF=1, OF=1. A cmovXX ifun=5 (ge) then gives e_cnd=1, and M_dstE equals e_dstE.
- cmovXX ifun=3 (e) with ZF=0 and e_dstE=3 → M_dstE=0xF, M_cnd=0.
- OPq with stall=1 → CC and all M_* unchanged. OPq with stall=1 and bubble=1 → unchanged. OPq with bubble=1 only → M_icode=NOP, M_valid=0, CC unchanged.
- OPq with m_exc=1 and alu_out=0 → CC is not updated (ZF keeps its old value), while M_valE=0 and M_icode=6 are still loaded.
